// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the 16x2 LCD text driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrup, StInit, StCfg, StFrame, StAddrA, StRowA, StAddrB, StRowB
  } lcd_state_e;

  typedef enum logic [1:0] {PhIssue, PhStrobe, PhWait} lcd_phase_e;

  localparam logic [7:0] LCD_FUNC_4B2L = 8'h28;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ADDR_L1   = 8'h80;
  localparam logic [7:0] LCD_ADDR_L2   = 8'hC0;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  // Configuration byte sent at each step of the config phase.
  function automatic logic [7:0] cfg_byte(input logic [1:0] step);
    logic [7:0] b;
    b = LCD_CLEAR;
    case (step)
      2'd0:    b = LCD_FUNC_4B2L;
      2'd1:    b = LCD_ENTRY_INC;
      2'd2:    b = LCD_DISP_ON;
      default: b = LCD_CLEAR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// Write-only 4-bit HD44780 bus between the text driver and the panel.
interface lcd_text_driver_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] LCD_D;

  modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_D);
  modport slave  (input LCD_E, input LCD_RS, input LCD_RW, input LCD_D);
endinterface

// File: rtl/lcd_nibble_strobe.sv
// Drives one nibble onto the LCD bus: setup with E low, fixed-width E pulse, one hold cycle.
module lcd_nibble_strobe #(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned E_HIGH_CYC = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic       rs_i,
  input  logic [3:0] nib_i,
  output logic       e_o,
  output logic       rs_o,
  output logic [3:0] d_o,
  output logic       done_o
);

  localparam int unsigned MaxCyc = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StHigh, StHold} strobe_state_e;

  strobe_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rs_q, rs_d;
  logic [3:0]      d_q, d_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    d_d     = d_q;
    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          state_d = StSetup;
          cnt_d   = '0;
          rs_d    = rs_i;
          d_d     = nib_i;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SETUP_CYC - 1)) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (cnt_q == CntW'(E_HIGH_CYC - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      d_q     <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      d_q     <= d_d;
    end
  end

  // RS/D stay registered past E falling, so the hold cycle comes for free.
  assign e_o    = (state_q == StHigh);
  assign done_o = (state_q == StHold);
  assign rs_o   = rs_q;
  assign d_o    = d_q;

endmodule

// File: rtl/lcd_text_driver.sv
// 16x2 HD44780 text driver: power-up init, config, then continuous two-row refresh in 4-bit mode.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC   = 2_000_000,
  parameter int unsigned INIT1_CYC   = 410_000,
  parameter int unsigned INIT2_CYC   = 10_000,
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned E_HIGH_CYC  = 24,
  parameter int unsigned NIB_GAP_CYC = 100,
  parameter int unsigned CMD_CYC     = 4_000,
  parameter int unsigned CLEAR_CYC   = 164_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [127:0]       row_A,
  input  logic [127:0]       row_B,
  lcd_text_driver_if.master  lcd,
  output logic               ready
);

  localparam int unsigned WaitW = $clog2(PWRUP_CYC + 1);

  lcd_state_e       state_q, state_d;
  lcd_phase_e       phase_q, phase_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1:0]       step_q, step_d;
  logic [3:0]       idx_q, idx_d;
  logic             hi_q, hi_d;
  logic             ready_q, ready_d;
  logic [127:0]     shadow_a_q, shadow_a_d;
  logic [127:0]     shadow_b_q, shadow_b_d;

  logic [7:0]       cur_byte;
  logic             cur_rs;
  logic [3:0]       cur_nib;
  logic [WaitW-1:0] wait_len;
  logic             go;
  logic             strobe_done;
  logic             strobe_e;
  logic             strobe_rs;
  logic [3:0]       strobe_d;

  // What goes on the bus next, and how long to wait once it has been strobed.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    case (state_q)
      StCfg:   cur_byte = cfg_byte(step_q);
      StAddrA: cur_byte = LCD_ADDR_L1;
      StAddrB: cur_byte = LCD_ADDR_L2;
      StRowA: begin
        cur_byte = shadow_a_q[{~idx_q, 3'b000} +: 8];
        cur_rs   = 1'b1;
      end
      StRowB: begin
        cur_byte = shadow_b_q[{~idx_q, 3'b000} +: 8];
        cur_rs   = 1'b1;
      end
      default: ;
    endcase

    if (state_q == StInit) begin
      cur_nib = (step_q == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
    end else begin
      cur_nib = hi_q ? cur_byte[7:4] : cur_byte[3:0];
    end

    wait_len = WaitW'(CMD_CYC);
    case (state_q)
      StPwrup: wait_len = WaitW'(PWRUP_CYC);
      StInit: begin
        if (step_q == 2'd0)      wait_len = WaitW'(INIT1_CYC);
        else if (step_q == 2'd1) wait_len = WaitW'(INIT2_CYC);
      end
      default: begin
        if (hi_q)                                      wait_len = WaitW'(NIB_GAP_CYC);
        else if (state_q == StCfg && step_q == 2'd3)   wait_len = WaitW'(CLEAR_CYC);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_d     = wait_q;
    step_d     = step_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    ready_d    = ready_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    go         = 1'b0;

    if (state_q == StFrame) begin
      // Snapshot both rows so a whole frame comes from one consistent image.
      shadow_a_d = row_A;
      shadow_b_d = row_B;
      state_d    = StAddrA;
      phase_d    = PhIssue;
      hi_d       = 1'b1;
      idx_d      = 4'd0;
    end else begin
      case (phase_q)
        PhIssue: begin
          go      = 1'b1;
          phase_d = PhStrobe;
        end
        PhStrobe: begin
          if (strobe_done) begin
            phase_d = PhWait;
            wait_d  = '0;
          end
        end
        PhWait: begin
          if (wait_q == wait_len - WaitW'(1)) begin
            wait_d  = '0;
            phase_d = PhIssue;
            case (state_q)
              StPwrup: begin
                state_d = StInit;
                step_d  = 2'd0;
              end
              StInit: begin
                if (step_q == 2'd3) begin
                  state_d = StCfg;
                  step_d  = 2'd0;
                  hi_d    = 1'b1;
                end else begin
                  step_d = step_q + 2'd1;
                end
              end
              default: begin
                if (hi_q) begin
                  hi_d = 1'b0;
                end else begin
                  hi_d = 1'b1;
                  case (state_q)
                    StCfg: begin
                      if (step_q == 2'd3) begin
                        state_d = StFrame;
                        ready_d = 1'b1;
                        step_d  = 2'd0;
                      end else begin
                        step_d = step_q + 2'd1;
                      end
                    end
                    StAddrA: state_d = StRowA;
                    StAddrB: state_d = StRowB;
                    StRowA: begin
                      idx_d = idx_q + 4'd1;
                      if (idx_q == 4'd15) state_d = StAddrB;
                    end
                    StRowB: begin
                      idx_d = idx_q + 4'd1;
                      if (idx_q == 4'd15) state_d = StFrame;
                    end
                    default: ;
                  endcase
                end
              end
            endcase
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        default: phase_d = PhWait;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StPwrup;
      phase_q    <= PhWait;
      wait_q     <= '0;
      step_q     <= 2'd0;
      idx_q      <= 4'd0;
      hi_q       <= 1'b1;
      ready_q    <= 1'b0;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      ready_q    <= ready_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
    end
  end

  lcd_nibble_strobe #(
    .SETUP_CYC  (SETUP_CYC),
    .E_HIGH_CYC (E_HIGH_CYC)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .go_i   (go),
    .rs_i   (cur_rs),
    .nib_i  (cur_nib),
    .e_o    (strobe_e),
    .rs_o   (strobe_rs),
    .d_o    (strobe_d),
    .done_o (strobe_done)
  );

  assign lcd.LCD_E  = strobe_e;
  assign lcd.LCD_RS = strobe_rs;
  assign lcd.LCD_D  = strobe_d;
  assign lcd.LCD_RW = 1'b0;
  assign ready      = ready_q;

endmodule
